// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser sampler: trigger mode codes, FSM states,
// and the pre-trigger depth clamp.
package la_pkg;

    localparam logic [1:0] TRIG_FALL  = 2'd0;
    localparam logic [1:0] TRIG_RISE  = 2'd1;
    localparam logic [1:0] TRIG_ANY   = 2'd2;
    localparam logic [1:0] TRIG_LEVEL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } la_state_e;

    function automatic int clamp_pre(input int req, input int pre_max);
        return (req > pre_max) ? pre_max : req;
    endfunction

endpackage

// File: rtl/la_ring_buffer.sv
// Purpose: circular sample FIFO with flush and internal drop-oldest; head is the entry at the read pointer.
// Latency: a push into an empty ring is visible on head_dat / !empty the next clock.
// Backpressure: a push into a full ring is dropped (drop=1) unless a pop/discard frees a slot in the same clock.
module la_ring_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         discard_oldest,
    input  logic [WIDTH-1:0]             push_dat,
    output logic [WIDTH-1:0]             head_dat,
    output logic                         full,
    output logic                         empty,
    output logic                         drop,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rd_en, wr_en;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign rd_en    = (pop || discard_oldest) && !empty;
    // A read in the same clock frees the slot, so a full-ring push is still accepted.
    assign wr_en    = push && (!full || rd_en);
    assign drop     = push && !wr_en;
    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (rd_en) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/la_sampler_core.sv
// Purpose: armed/triggered multi-channel capture engine; LA_PRETRIG_EN adds a PRE_MAX-entry pre-trigger history.
// Latency: pin to s_d 2 clocks; a pushed sample reaches wr_valid 1 clock later.
// Backpressure: wr_valid/wr_ready; samples pushed into a full ring are dropped and flagged by sticky overflow.
module la_sampler_core
    import la_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int DEPTH_W = 12,
    parameter int PRE_MAX = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PD_W   = $clog2(PRE_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               abort,
    input  logic [CH_W-1:0]    trigger_ch,
    input  logic [1:0]         trig_mode,
    input  logic [15:0]        div_cnt,
    input  logic [DEPTH_W-1:0] sample_depth,
    input  logic [PD_W-1:0]    pre_depth,
    input  logic [NUM_CH-1:0]  data_in,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [NUM_CH-1:0]  wr_data,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

`ifdef LA_PRETRIG_EN
    localparam int RING_DEPTH = PRE_MAX;
`else
    localparam int RING_DEPTH = 1;
`endif
    localparam int CNT_W = $clog2(RING_DEPTH + 1);

    la_state_e          state_q, state_d;
    logic [NUM_CH-1:0]  sync1_q, s_q, prev_q;
    logic [CH_W-1:0]    trig_ch_q, trig_ch_d;
    logic [1:0]         mode_q, mode_d;
    logic [15:0]        div_q, div_d, div_cnt_q, div_cnt_d;
    logic [DEPTH_W-1:0] depth_q, depth_d, sample_cnt_q, sample_cnt_d, depth_eff;
    logic               overflow_q, overflow_d, done_q, done_d;
    logic               cur_bit, prev_bit, hit, strobe, out_en;
    logic               push, pop, flush, discard;
    logic               ring_full, ring_empty, ring_drop;
    logic [CNT_W-1:0]   ring_count;
    logic               unused_ok;
`ifdef LA_PRETRIG_EN
    logic [PD_W-1:0]    pre_q, pre_d;
    assign unused_ok = ring_full;
`else
    assign unused_ok = ^{ring_full, pre_depth};
`endif

    // Channel selects outside 0..NUM_CH-1 match nothing, so the trigger never fires.
    always_comb begin
        cur_bit  = 1'b0;
        prev_bit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (trig_ch_q == CH_W'(i)) begin
                cur_bit  = s_q[i];
                prev_bit = prev_q[i];
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        if (state_q == ST_ARMED) begin
            case (mode_q)
                TRIG_FALL:  hit = prev_bit & ~cur_bit;
                TRIG_RISE:  hit = ~prev_bit & cur_bit;
                TRIG_ANY:   hit = prev_bit ^ cur_bit;
                default:    hit = cur_bit;
            endcase
        end
    end

    assign strobe    = (div_q <= 16'd1) || (div_cnt_q == div_q - 16'd1);
    assign depth_eff = (depth_q == '0) ? DEPTH_W'(1) : depth_q;
    assign out_en    = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
    assign wr_valid  = out_en && !ring_empty;
    assign pop       = wr_valid && wr_ready;

    always_comb begin
        state_d      = state_q;
        trig_ch_d    = trig_ch_q;
        mode_d       = mode_q;
        div_d        = div_q;
        depth_d      = depth_q;
        sample_cnt_d = sample_cnt_q;
        overflow_d   = overflow_q | ring_drop;
        done_d       = 1'b0;
        push         = 1'b0;
        flush        = 1'b0;
        discard      = 1'b0;
        div_cnt_d    = '0;
`ifdef LA_PRETRIG_EN
        pre_d        = pre_q;
`endif
        if ((state_q == ST_ARMED) || (state_q == ST_CAPTURE)) begin
            div_cnt_d = (hit || strobe) ? 16'd0 : div_cnt_q + 16'd1;
        end

        if (abort) begin
            state_d      = ST_IDLE;
            flush        = 1'b1;
            sample_cnt_d = '0;
            div_cnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d      = ST_ARMED;
                        flush        = 1'b1;
                        sample_cnt_d = '0;
                        overflow_d   = 1'b0;
                        trig_ch_d    = trigger_ch;
                        mode_d       = trig_mode;
                        div_d        = div_cnt;
                        depth_d      = sample_depth;
`ifdef LA_PRETRIG_EN
                        pre_d        = PD_W'(clamp_pre(int'(pre_depth), PRE_MAX));
`endif
                    end
                end
                ST_ARMED: begin
                    if (hit) begin
                        push         = 1'b1;
                        sample_cnt_d = DEPTH_W'(1);
                        state_d      = (depth_eff == DEPTH_W'(1)) ? ST_DRAIN : ST_CAPTURE;
                    end
`ifdef LA_PRETRIG_EN
                    // History window: keep only the newest pre_q samples.
                    else if (strobe && (pre_q != '0)) begin
                        push    = 1'b1;
                        discard = (ring_count >= CNT_W'(pre_q));
                    end
`endif
                end
                ST_CAPTURE: begin
                    if (strobe) begin
                        push         = 1'b1;
                        sample_cnt_d = sample_cnt_q + DEPTH_W'(1);
                        if (sample_cnt_q == depth_eff - DEPTH_W'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                default: begin
                    if (ring_empty || ((ring_count == CNT_W'(1)) && pop)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    la_ring_buffer #(
        .WIDTH (NUM_CH),
        .DEPTH (RING_DEPTH)
    ) u_ring (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .push           (push),
        .pop            (pop),
        .discard_oldest (discard),
        .push_dat       (s_q),
        .head_dat       (wr_data),
        .full           (ring_full),
        .empty          (ring_empty),
        .drop           (ring_drop),
        .count          (ring_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            s_q          <= '0;
            prev_q       <= '0;
            state_q      <= ST_IDLE;
            trig_ch_q    <= '0;
            mode_q       <= '0;
            div_q        <= '0;
            div_cnt_q    <= '0;
            depth_q      <= '0;
            sample_cnt_q <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
`ifdef LA_PRETRIG_EN
            pre_q        <= '0;
`endif
        end else begin
            sync1_q      <= data_in;
            s_q          <= sync1_q;
            prev_q       <= s_q;
            state_q      <= state_d;
            trig_ch_q    <= trig_ch_d;
            mode_q       <= mode_d;
            div_q        <= div_d;
            div_cnt_q    <= div_cnt_d;
            depth_q      <= depth_d;
            sample_cnt_q <= sample_cnt_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
`ifdef LA_PRETRIG_EN
            pre_q        <= pre_d;
`endif
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_la_sampler_core.sv
// Directed bench for la_sampler_core: trigger modes, divider timing, overflow, abort, re-arm and corner cases.
module tb_la_sampler_core;

    localparam int NUM_CH  = 6;
    localparam int DEPTH_W = 12;
    localparam int PRE_MAX = 16;
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int PD_W    = $clog2(PRE_MAX + 1);
`ifdef LA_PRETRIG_EN
    localparam int CAP = PRE_MAX;
`else
    localparam int CAP = 1;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               arm = 1'b0;
    logic               abort = 1'b0;
    logic [CH_W-1:0]    trigger_ch = '0;
    logic [1:0]         trig_mode = '0;
    logic [15:0]        div_cnt = '0;
    logic [DEPTH_W-1:0] sample_depth = '0;
    logic [PD_W-1:0]    pre_depth = '0;
    logic [NUM_CH-1:0]  data_in = '0;
    logic               wr_valid;
    logic               wr_ready = 1'b1;
    logic [NUM_CH-1:0]  wr_data;
    logic               busy, done, overflow;

    int n_cmp = 0;
    int n_bad = 0;
    logic [NUM_CH-1:0] beat_dat [64];
    int                beat_cyc [64];
    int                n_beats;
    int                done_cyc;

    la_sampler_core #(.NUM_CH(NUM_CH), .DEPTH_W(DEPTH_W), .PRE_MAX(PRE_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trigger_ch(trigger_ch),
        .trig_mode(trig_mode), .div_cnt(div_cnt), .sample_depth(sample_depth),
        .pre_depth(pre_depth), .data_in(data_in), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [CH_W-1:0] ch, input logic [1:0] mode, input logic [15:0] div,
                          input logic [DEPTH_W-1:0] depth, input logic [PD_W-1:0] pre);
        trigger_ch = ch; trig_mode = mode; div_cnt = div; sample_depth = depth; pre_depth = pre;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Samples the current cycle first, then advances; cycle index 0 is the cycle the call starts in.
    task automatic collect(input int budget);
        n_beats  = 0;
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (wr_valid && wr_ready && n_beats < 64) begin
                beat_dat[n_beats] = wr_data;
                beat_cyc[n_beats] = i;
                n_beats++;
            end
            if (done) begin
                done_cyc = i;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (wr_data !== '0) begin n_bad++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rising_div1();
        data_in = '0; wr_ready = 1'b1;
        repeat (3) tick();
        do_arm(3'd3, 2'd1, 16'd1, 12'd8, '0);
        repeat (2) tick();
        data_in = 6'h08;
        collect(40);
        n_cmp++; if (n_beats !== 8) begin n_bad++; $display("FAIL t1_beats: got %0d want 8", n_beats); end
        n_cmp++; if (beat_cyc[0] !== 3) begin n_bad++; $display("FAIL t1_first_cyc: got %0d want 3", beat_cyc[0]); end
        n_cmp++; if (beat_cyc[7] !== 10) begin n_bad++; $display("FAIL t1_last_cyc: got %0d want 10", beat_cyc[7]); end
        n_cmp++; if (beat_dat[0][3] !== 1'b1) begin n_bad++; $display("FAIL t1_first_bit3: got %b want 1", beat_dat[0][3]); end
        n_cmp++; if (done_cyc !== 11) begin n_bad++; $display("FAIL t1_done_cyc: got %0d want 11", done_cyc); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_busy_at_done: got %b want 0", busy); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL t1_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_falling_div4();
        int busy11;
        logic [NUM_CH-1:0] exp_d [3];
        exp_d = '{6'h00, 6'h10, 6'h20};
        busy11 = -1;
        data_in = 6'h01; wr_ready = 1'b1;
        repeat (3) tick();
        do_arm(3'd0, 2'd0, 16'd4, 12'd3, '0);
        repeat (2) tick();
        data_in = 6'h00;
        n_beats = 0; done_cyc = -1;
        for (int k = 0; k < 30 && done_cyc < 0; k++) begin
            if (k == 4) data_in = 6'h10;
            if (k == 8) data_in = 6'h20;
            if (wr_valid && n_beats < 64) begin
                beat_dat[n_beats] = wr_data; beat_cyc[n_beats] = k; n_beats++;
            end
            if (k == 11) busy11 = int'(busy);
            if (done) done_cyc = k;
            else tick();
        end
        n_cmp++; if (n_beats !== 3) begin n_bad++; $display("FAIL t2_beats: got %0d want 3", n_beats); end
        n_cmp++; if (beat_cyc[0] !== 3) begin n_bad++; $display("FAIL t2_first_cyc: got %0d want 3", beat_cyc[0]); end
        n_cmp++; if (beat_cyc[1] - beat_cyc[0] !== 4) begin n_bad++; $display("FAIL t2_gap1: got %0d want 4", beat_cyc[1] - beat_cyc[0]); end
        n_cmp++; if (beat_cyc[2] - beat_cyc[1] !== 4) begin n_bad++; $display("FAIL t2_gap2: got %0d want 4", beat_cyc[2] - beat_cyc[1]); end
        for (int j = 0; j < 3; j++) begin
            n_cmp++; if (beat_dat[j] !== exp_d[j]) begin n_bad++; $display("FAIL t2_data%0d: got %h want %h", j, beat_dat[j], exp_d[j]); end
        end
        n_cmp++; if (done_cyc !== 12) begin n_bad++; $display("FAIL t2_done_cyc: got %0d want 12", done_cyc); end
        n_cmp++; if (busy11 !== 1) begin n_bad++; $display("FAIL t2_busy_before_done: got %0d want 1", busy11); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t2_busy_with_done: got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        data_in = 6'h00; wr_ready = 1'b0;
        repeat (3) tick();
        do_arm(3'd1, 2'd1, 16'd1, 12'd20, '0);
        repeat (2) tick();
        data_in = 6'h02;
        repeat (30) tick();
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL t3_overflow: got %b want 1", overflow); end
        n_cmp++; if (wr_valid !== 1'b1) begin n_bad++; $display("FAIL t3_valid_held: got %b want 1", wr_valid); end
        wr_ready = 1'b1;
        collect(60);
        n_cmp++; if (n_beats !== CAP) begin n_bad++; $display("FAIL t3_retained: got %0d want %0d", n_beats, CAP); end
        n_cmp++; if (beat_dat[0] !== 6'h02) begin n_bad++; $display("FAIL t3_data: got %h want 02", beat_dat[0]); end
        n_cmp++; if (done_cyc !== CAP) begin n_bad++; $display("FAIL t3_done_cyc: got %0d want %0d", done_cyc, CAP); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL t3_overflow_sticky: got %b want 1", overflow); end
    endtask

`ifdef LA_PRETRIG_EN
    task automatic test_pretrig();
        logic [NUM_CH-1:0] exp_d [7];
        exp_d = '{6'h0E, 6'h10, 6'h12, 6'h14, 6'h21, 6'h21, 6'h21};
        data_in = 6'h00; wr_ready = 1'b1;
        repeat (3) tick();
        do_arm(3'd0, 2'd3, 16'd1, 12'd3, 5'd4);
        for (int k = 1; k <= 10; k++) begin
            data_in = NUM_CH'(2 * k);
            tick();
        end
        data_in = 6'h21;
        collect(40);
        n_cmp++; if (n_beats !== 7) begin n_bad++; $display("FAIL t4_beats: got %0d want 7", n_beats); end
        for (int j = 0; j < 7; j++) begin
            n_cmp++; if (beat_dat[j] !== exp_d[j]) begin n_bad++; $display("FAIL t4_data%0d: got %h want %h", j, beat_dat[j], exp_d[j]); end
        end
        n_cmp++; if (done_cyc < 0) begin n_bad++; $display("FAIL t4_done: got timeout want done"); end
    endtask
`endif

    task automatic test_abort_rearm();
        int done_seen;
        data_in = 6'h00; wr_ready = 1'b0;
        repeat (3) tick();
        do_arm(3'd2, 2'd1, 16'd1, 12'd40, '0);
        repeat (2) tick();
        data_in = 6'h04;
        repeat (25) tick();
        n_cmp++; if (wr_valid !== 1'b1) begin n_bad++; $display("FAIL t5_valid_before: got %b want 1", wr_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL t5_overflow_before: got %b want 1", overflow); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t5_busy: got %b want 0", busy); end
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL t5_valid: got %b want 0", wr_valid); end
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (done) done_seen = 1;
            tick();
        end
        n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL t5_no_done: got %0d want 0", done_seen); end
        wr_ready = 1'b1;
        do_arm(3'd2, 2'd3, 16'd1, 12'd1, '0);
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL t5_overflow_cleared: got %b want 0", overflow); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t5_rearm_busy: got %b want 1", busy); end
        collect(20);
        n_cmp++; if (n_beats !== 1) begin n_bad++; $display("FAIL t5_rearm_beats: got %0d want 1", n_beats); end
        n_cmp++; if (beat_dat[0] !== 6'h04) begin n_bad++; $display("FAIL t5_rearm_data: got %h want 04", beat_dat[0]); end
        n_cmp++; if (done_cyc !== 2) begin n_bad++; $display("FAIL t5_rearm_done_cyc: got %0d want 2", done_cyc); end
    endtask

    task automatic test_corner_cases();
        int vld_seen;
        // Channel index 7 does not exist with six channels.
        data_in = 6'h00; wr_ready = 1'b1;
        repeat (3) tick();
        do_arm(3'd7, 2'd2, 16'd1, 12'd2, '0);
        vld_seen = 0;
        for (int k = 0; k < 12; k++) begin
            data_in = (k % 2 == 0) ? 6'h3F : 6'h00;
            if (wr_valid) vld_seen++;
            tick();
        end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t6_badch_armed: got %b want 1", busy); end
        n_cmp++; if (vld_seen !== 0) begin n_bad++; $display("FAIL t6_badch_beats: got %0d want 0", vld_seen); end
        abort = 1'b1; tick(); abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t6_badch_abort: got %b want 0", busy); end

        data_in = 6'h00;
        repeat (3) tick();
        do_arm(3'd4, 2'd1, 16'd1, 12'd0, '0);
        repeat (2) tick();
        data_in = 6'h10;
        collect(20);
        n_cmp++; if (n_beats !== 1) begin n_bad++; $display("FAIL t6_depth0_beats: got %0d want 1", n_beats); end
        n_cmp++; if (beat_dat[0] !== 6'h10) begin n_bad++; $display("FAIL t6_depth0_data: got %h want 10", beat_dat[0]); end
        n_cmp++; if (done_cyc !== 4) begin n_bad++; $display("FAIL t6_depth0_done_cyc: got %0d want 4", done_cyc); end

        data_in = 6'h00;
        repeat (3) tick();
        do_arm(3'd1, 2'd2, 16'd2, 12'd4, '0);
        repeat (2) tick();
        data_in = 6'h02;
        n_beats = 0; done_cyc = -1;
        for (int k = 0; k < 40 && done_cyc < 0; k++) begin
            if (k == 5) begin sample_depth = 12'd9; arm = 1'b1; end
            if (k == 6) arm = 1'b0;
            if (wr_valid && wr_ready && n_beats < 64) begin
                beat_cyc[n_beats] = k; n_beats++;
            end
            if (done) done_cyc = k;
            else tick();
        end
        arm = 1'b0;
        n_cmp++; if (n_beats !== 4) begin n_bad++; $display("FAIL t6_rearm_ignored_beats: got %0d want 4", n_beats); end
        n_cmp++; if (beat_cyc[1] !== 5) begin n_bad++; $display("FAIL t6_div2_second_cyc: got %0d want 5", beat_cyc[1]); end
        n_cmp++; if (done_cyc !== 10) begin n_bad++; $display("FAIL t6_rearm_ignored_done: got %0d want 10", done_cyc); end
    endtask

    initial begin
        test_reset();
        test_rising_div1();
        test_falling_div4();
        test_overflow();
`ifdef LA_PRETRIG_EN
        test_pretrig();
`endif
        test_abort_rearm();
        test_corner_cases();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
